// File: rtl/spi_slave_if.sv
// Host register bus of the SPI responder.
// Write strobe, address and data in; read data and interrupt out.
interface spi_slave_if;
  logic [7:0] DataWr;
  logic [1:0] Addr;
  logic       Wr;
  logic [7:0] DataRd;
  logic       Irq;

  modport master (
    output DataWr, Addr, Wr,
    input  DataRd, Irq
  );

  modport slave (
    input  DataWr, Addr, Wr,
    output DataRd, Irq
  );
endinterface

// File: rtl/spi_slave.sv
// SPI responder, modes 0-3, MSB-first 8-bit frames.
// Pins are oversampled in the Clk domain through 2-flop synchronizers.
module spi_slave (
  input  logic        Clk,
  input  logic        Rst_n,
  spi_slave_if.slave  bus,
  input  logic        SCK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_En
);

  logic [1:0] sck_s_q;
  logic [1:0] ss_s_q;
  logic [1:0] mosi_s_q;
  logic       sck_d_q;
  logic       ss_d_q;
  logic       armed_q, armed_d;

  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [7:0] txbuf_q, txbuf_d;
  logic [7:0] rxbuf_q, rxbuf_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rxv_q, rxv_d;
  logic       ovr_q, ovr_d;
  logic       txe_q, txe_d;

  logic busy, ss_fall;
  logic sck_rise, sck_fall;
  logic lead, trail;
  logic smp_ev, drv_ev;
  logic wr_cfg, wr_sta, wr_tx, wr_rx;
  logic [7:0] rx_byte;

  // Only a high SS_n seen after reset arms the block, so a
  // transfer cut by reset is not resumed mid-frame.
  assign armed_d  = armed_q | ss_s_q[1];
  assign busy     = armed_q & ~ss_s_q[1];
  assign ss_fall  = busy & ss_d_q;

  assign sck_rise = sck_s_q[1] & ~sck_d_q;
  assign sck_fall = ~sck_s_q[1] & sck_d_q;
  assign lead     = cpol_q ? sck_fall : sck_rise;
  assign trail    = cpol_q ? sck_rise : sck_fall;

  assign smp_ev   = busy & (cpha_q ? trail : lead);
  assign drv_ev   = busy & (cpha_q ? lead : (trail | ss_fall));

  assign wr_cfg   = bus.Wr & (bus.Addr == 2'd0);
  assign wr_sta   = bus.Wr & (bus.Addr == 2'd1);
  assign wr_tx    = bus.Wr & (bus.Addr == 2'd2);
  assign wr_rx    = bus.Wr & (bus.Addr == 2'd3);

  assign rx_byte  = {rx_sh_q[6:0], mosi_s_q[1]};

  always_comb begin
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    txbuf_d = txbuf_q;
    rxbuf_d = rxbuf_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    cnt_d   = cnt_q;
    rxv_d   = rxv_q;
    ovr_d   = ovr_q;
    txe_d   = txe_q;

    if (wr_cfg && !busy) begin
      cpol_d = bus.DataWr[5];
      cpha_d = bus.DataWr[4];
    end
    if (wr_sta)
      ovr_d = 1'b0;

    // A load sees the old TXBUF; a same-cycle write still leaves it full.
    if (drv_ev) begin
      if (cnt_q == 3'd0) begin
        tx_sh_d = txbuf_q;
        txe_d   = 1'b1;
      end else begin
        tx_sh_d = {tx_sh_q[6:0], 1'b0};
      end
    end
    if (wr_tx) begin
      txbuf_d = bus.DataWr;
      txe_d   = 1'b0;
    end

    if (wr_rx)
      rxv_d = 1'b0;

    if (!busy) begin
      cnt_d = 3'd0;
    end else if (smp_ev) begin
      rx_sh_d = rx_byte;
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        if (!rxv_q || wr_rx) begin
          rxbuf_d = rx_byte;
          rxv_d   = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sck_s_q  <= 2'b00;
      ss_s_q   <= 2'b00;
      mosi_s_q <= 2'b00;
      sck_d_q  <= 1'b0;
      ss_d_q   <= 1'b0;
      armed_q  <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      txbuf_q  <= 8'h00;
      rxbuf_q  <= 8'h00;
      tx_sh_q  <= 8'h00;
      rx_sh_q  <= 8'h00;
      cnt_q    <= 3'd0;
      rxv_q    <= 1'b0;
      ovr_q    <= 1'b0;
      txe_q    <= 1'b1;
    end else begin
      sck_s_q  <= {sck_s_q[0], SCK};
      ss_s_q   <= {ss_s_q[0], SS_n};
      mosi_s_q <= {mosi_s_q[0], MOSI};
      sck_d_q  <= sck_s_q[1];
      ss_d_q   <= ss_s_q[1];
      armed_q  <= armed_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      txbuf_q  <= txbuf_d;
      rxbuf_q  <= rxbuf_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      cnt_q    <= cnt_d;
      rxv_q    <= rxv_d;
      ovr_q    <= ovr_d;
      txe_q    <= txe_d;
    end
  end

  assign MISO    = tx_sh_q[7];
  assign MISO_En = busy;
  assign bus.Irq = rxv_q | ovr_q;

  always_comb begin
    bus.DataRd = 8'h00;
    case (bus.Addr)
      2'd0: bus.DataRd = {2'b00, cpol_q, cpha_q, 4'h0};
      2'd1: bus.DataRd = {4'h0, txe_q, ovr_q, rxv_q, busy};
      2'd2: bus.DataRd = txbuf_q;
      2'd3: bus.DataRd = rxbuf_q;
      default: bus.DataRd = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a cycle-timed SPI master model
// and host register accesses with hand-computed expectations.
module tb_spi_slave;

  logic Clk = 1'b0;
  logic Rst_n;
  logic SCK, SS_n, MOSI;
  logic MISO, MISO_En;
  logic cpol, cpha;
  logic [7:0] r;
  int checks = 0;
  int errors = 0;

  spi_slave_if bus ();

  spi_slave dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .bus     (bus),
    .SCK     (SCK),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .MISO_En (MISO_En)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge Clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge Clk);
    bus.Addr = a;
    bus.DataWr = d;
    bus.Wr = 1'b1;
    @(negedge Clk);
    bus.Wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [7:0] exp);
    @(negedge Clk);
    bus.Addr = a;
    #1 check(tag, bus.DataRd, exp);
  endtask

  task automatic ss_low();
    SS_n = 1'b0;
    half();
  endtask

  task automatic ss_high();
    half();
    SS_n = 1'b1;
    half();
  endtask

  task automatic xfer(input logic [7:0] tx, input int nb,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      if (!cpha) begin
        MOSI = tx[i];
        half();
        SCK = ~SCK;
        rx[i] = MISO;
        half();
        SCK = ~SCK;
        half();
      end else begin
        SCK = ~SCK;
        MOSI = tx[i];
        half();
        SCK = ~SCK;
        rx[i] = MISO;
        half();
      end
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    SCK = 1'b0;
    SS_n = 1'b1;
    MOSI = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    bus.Wr = 1'b0;
    bus.Addr = 2'd0;
    bus.DataWr = 8'h00;
    repeat (3) @(negedge Clk);

    rd("rst_cfg", 2'd0, 8'h00);
    rd("rst_status", 2'd1, 8'h08);
    rd("rst_txbuf", 2'd2, 8'h00);
    rd("rst_rxbuf", 2'd3, 8'h00);
    check("rst_miso", {7'd0, MISO}, 8'h00);
    check("rst_misoen", {7'd0, MISO_En}, 8'h00);
    check("rst_irq", {7'd0, bus.Irq}, 8'h00);
    Rst_n = 1'b1;
    half();

    // mode 0 exchange
    wr(2'd2, 8'hA6);
    rd("m0_txfull", 2'd1, 8'h00);
    ss_low();
    check("m0_misoen", {7'd0, MISO_En}, 8'h01);
    xfer(8'h5B, 8, r);
    ss_high();
    check("m0_master_rx", r, 8'hA6);
    rd("m0_rxbuf", 2'd3, 8'h5B);
    rd("m0_status", 2'd1, 8'h0A);
    check("m0_irq", {7'd0, bus.Irq}, 8'h01);
    check("m0_misoen_off", {7'd0, MISO_En}, 8'h00);
    wr(2'd3, 8'h00);
    rd("m0_ack", 2'd1, 8'h08);

    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      SCK = cpol;
      half();
      wr(2'd0, {2'b00, cpol, cpha, 4'h0});
      rd($sformatf("m%0d_cfg", m), 2'd0, {2'b00, cpol, cpha, 4'h0});
      wr(2'd2, 8'hA6);
      ss_low();
      check($sformatf("m%0d_misoen", m), {7'd0, MISO_En}, 8'h01);
      xfer(8'h5B, 8, r);
      ss_high();
      check($sformatf("m%0d_master_rx", m), r, 8'hA6);
      rd($sformatf("m%0d_rxbuf", m), 2'd3, 8'h5B);
      rd($sformatf("m%0d_status", m), 2'd1, 8'h0A);
      check($sformatf("m%0d_misoen_off", m), {7'd0, MISO_En}, 8'h00);
      wr(2'd3, 8'h00);
    end

    // back to mode 0
    cpol = 1'b0;
    cpha = 1'b0;
    SCK = 1'b0;
    half();
    wr(2'd0, 8'h00);
    rd("cfg_m0", 2'd0, 8'h00);

    // overrun
    ss_low();
    xfer(8'h11, 8, r);
    ss_high();
    ss_low();
    xfer(8'h22, 8, r);
    ss_high();
    rd("ovr_rxbuf", 2'd3, 8'h11);
    rd("ovr_status", 2'd1, 8'h0E);
    wr(2'd1, 8'h00);
    rd("ovr_clr", 2'd1, 8'h0A);
    check("ovr_irq_hold", {7'd0, bus.Irq}, 8'h01);
    wr(2'd3, 8'h00);
    rd("ovr_ack", 2'd1, 8'h08);
    check("ovr_irq_low", {7'd0, bus.Irq}, 8'h00);

    // burst of two bytes
    wr(2'd2, 8'h3C);
    ss_low();
    rd("bu_loaded", 2'd1, 8'h09);
    wr(2'd2, 8'h81);
    xfer(8'h5B, 8, r);
    check("bu_rx0", r, 8'h3C);
    rd("bu_rxbuf0", 2'd3, 8'h5B);
    wr(2'd3, 8'h00);
    xfer(8'hC3, 8, r);
    check("bu_rx1", r, 8'h81);
    ss_high();
    wr(2'd3, 8'h00);
    rd("bu_rxbuf1", 2'd3, 8'hC3);
    rd("bu_status", 2'd1, 8'h08);

    // SS abort after 4 bits
    wr(2'd2, 8'h55);
    ss_low();
    xfer(8'h0F, 4, r);
    ss_high();
    rd("ab_status", 2'd1, 8'h08);
    rd("ab_rxbuf", 2'd3, 8'hC3);
    ss_low();
    xfer(8'h96, 8, r);
    ss_high();
    check("ab_resend", r, 8'h55);
    rd("ab_rxbuf2", 2'd3, 8'h96);
    check("ab_irq", {7'd0, bus.Irq}, 8'h01);

    // reset during bit 3
    wr(2'd2, 8'h5A);
    ss_low();
    xfer(8'hF0, 3, r);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("rm_miso", {7'd0, MISO}, 8'h00);
    check("rm_misoen", {7'd0, MISO_En}, 8'h00);
    check("rm_irq", {7'd0, bus.Irq}, 8'h00);
    rd("rm_rxbuf", 2'd3, 8'h00);
    rd("rm_txbuf", 2'd2, 8'h00);
    rd("rm_status", 2'd1, 8'h08);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    half();
    rd("rm_unarmed", 2'd1, 8'h08);
    check("rm_unarmed_en", {7'd0, MISO_En}, 8'h00);
    ss_high();
    wr(2'd2, 8'hC5);
    ss_low();
    xfer(8'h7E, 8, r);
    ss_high();
    check("rm_master_rx", r, 8'hC5);
    rd("rm_rxbuf2", 2'd3, 8'h7E);
    rd("rm_status2", 2'd1, 8'h0A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
